// File: rtl/baud_gen_frac.sv
// Fractional-N baud enable generator: phase-accumulator carry drives oversample, bit-rate and mid-bit strobes.
// All outputs registered one cycle after the carry edge; no backpressure, en=0 freezes phase and zeroes outputs.
module baud_gen_frac #(
   parameter int          ACC_WIDTH   = 16,
   parameter int          OVERSAMPLE  = 16,
   parameter int unsigned DEFAULT_INC = 1887
) (
   input  logic                 clk_50m,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [ACC_WIDTH-1:0] inc_in,
   input  logic                 inc_load,
   input  logic                 rx_sync,
   output logic                 rxclk_en,
   output logic                 txclk_en,
   output logic                 rx_sample
);

   localparam int             CW       = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0]  DIV_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0]  MID_LAST = CW'(OVERSAMPLE / 2 - 1);

   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] r_inc;
   logic [CW-1:0]        r_tx_div;
   logic [CW-1:0]        r_rx_phase;
   logic                 r_rxclk_en;
   logic                 r_txclk_en;
   logic                 r_rx_sample;

   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_tick;

   assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};
   assign w_tick = en & w_sum[ACC_WIDTH];

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_inc <= ACC_WIDTH'(DEFAULT_INC);
      end else begin
         if (en)
            r_acc <= w_sum[ACC_WIDTH-1:0];
         // acc is deliberately left alone so a rate change keeps phase continuity
         if (inc_load)
            r_inc <= inc_in;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_div   <= '0;
         r_rx_phase <= '0;
      end else begin
         if (w_tick)
            r_tx_div <= (r_tx_div == DIV_LAST) ? '0 : r_tx_div + CW'(1);
         // a start edge restarts the bit phase and swallows any coincident tick
         if (rx_sync)
            r_rx_phase <= '0;
         else if (w_tick)
            r_rx_phase <= (r_rx_phase == DIV_LAST) ? '0 : r_rx_phase + CW'(1);
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_rxclk_en  <= 1'b0;
         r_txclk_en  <= 1'b0;
         r_rx_sample <= 1'b0;
      end else begin
         r_rxclk_en  <= w_tick;
         r_txclk_en  <= w_tick && (r_tx_div == DIV_LAST);
         r_rx_sample <= w_tick && (r_rx_phase == MID_LAST) && !rx_sync;
      end
   end

   assign rxclk_en  = r_rxclk_en;
   assign txclk_en  = r_txclk_en;
   assign rx_sample = r_rx_sample;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: randomized and directed stimulus against a phase/tick-count reference model.
module tb_baud_gen_frac;
   localparam int W   = 16;
   localparam int OS  = 16;
   localparam int DEF = 1887;
   localparam int MOD = 65536;

   logic         clk_50m = 1'b0;
   logic         rst_n   = 1'b0;
   logic         en      = 1'b0;
   logic [W-1:0] inc_in  = '0;
   logic         inc_load = 1'b0;
   logic         rx_sync  = 1'b0;
   logic         rxclk_en, txclk_en, rx_sample;

   int checks = 0;
   int errors = 0;

   // reference model: fractional phase in [0,1) scaled by 2^W, plus tick counters
   int   m_phase, m_inc, m_ticks, m_since;
   logic exp_rx, exp_tx, exp_smp;

   baud_gen_frac #(.ACC_WIDTH(W), .OVERSAMPLE(OS), .DEFAULT_INC(DEF)) dut (
      .clk_50m(clk_50m), .rst_n(rst_n), .en(en), .inc_in(inc_in),
      .inc_load(inc_load), .rx_sync(rx_sync),
      .rxclk_en(rxclk_en), .txclk_en(txclk_en), .rx_sample(rx_sample)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic model_reset();
      m_phase = 0; m_inc = DEF; m_ticks = 0; m_since = 0;
      exp_rx = 1'b0; exp_tx = 1'b0; exp_smp = 1'b0;
   endtask

   // drive one cycle of inputs, advance the model across the edge, return at the negedge
   task automatic step(input logic e, input logic ld, input logic [W-1:0] v, input logic sy);
      logic tick;
      en = e; inc_load = ld; inc_in = v; rx_sync = sy;
      @(posedge clk_50m);
      tick = 1'b0;
      if (e) begin
         m_phase = m_phase + m_inc;
         if (m_phase >= MOD) begin
            m_phase = m_phase - MOD;
            tick = 1'b1;
         end
      end
      if (tick) m_ticks++;
      if (sy) m_since = 0;
      else if (tick) m_since++;
      exp_rx  = tick;
      exp_tx  = tick && (m_ticks % OS == 0);
      exp_smp = tick && !sy && (m_since % OS == OS / 2);
      if (ld) m_inc = int'(v);
      @(negedge clk_50m);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_50m);
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: got %b%b%b want 000", i, rxclk_en, txclk_en, rx_sample);
         end
      end
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_default_rate();
      int first_rx = 0, n_rx = 0, n_tx = 0, rx_at_tx = 0;
      logic prev_rx = 1'b0;
      for (int i = 1; i <= MOD; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== {exp_rx, exp_tx, exp_smp}) begin
            errors++;
            $display("FAIL default_rate edge %0d: got rx/tx/smp %b%b%b want %b%b%b",
                     i, rxclk_en, txclk_en, rx_sample, exp_rx, exp_tx, exp_smp);
         end
         if (rxclk_en === 1'b1) begin
            n_rx++;
            if (first_rx == 0) first_rx = i;
            checks++;
            if (prev_rx === 1'b1) begin
               errors++;
               $display("FAIL pulse_width edge %0d: rxclk_en high two cycles, want one", i);
            end
         end
         if (txclk_en === 1'b1) begin
            n_tx++;
            if (rx_at_tx == 0) rx_at_tx = n_rx;
         end
         prev_rx = rxclk_en;
      end
      checks++; if (first_rx != 35)  begin errors++; $display("FAIL first_rx edge: got %0d want 35", first_rx); end
      checks++; if (n_rx != 1887)    begin errors++; $display("FAIL default_rx_count: got %0d want 1887", n_rx); end
      checks++; if (n_tx != 117)     begin errors++; $display("FAIL default_tx_count: got %0d want 117", n_tx); end
      checks++; if (rx_at_tx != 16)  begin errors++; $display("FAIL first_tx position: got rx #%0d want 16", rx_at_tx); end
   endtask

   task automatic test_reprogram();
      int last_rx = -1, last_tx = -1, n_iv = 0, n_after_zero = 0;
      step(1'b1, 1'b1, 16'd4096, 1'b0);
      for (int i = 0; i < 600; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== {exp_rx, exp_tx, exp_smp}) begin
            errors++;
            $display("FAIL reprogram cycle %0d: got %b%b%b want %b%b%b",
                     i, rxclk_en, txclk_en, rx_sample, exp_rx, exp_tx, exp_smp);
         end
         if (rxclk_en === 1'b1) begin
            if (last_rx >= 0) begin
               n_iv++; checks++;
               if (i - last_rx != 16) begin errors++; $display("FAIL rx_interval: got %0d want 16", i - last_rx); end
            end
            last_rx = i;
         end
         if (txclk_en === 1'b1) begin
            if (last_tx >= 0) begin
               checks++;
               if (i - last_tx != 256) begin errors++; $display("FAIL tx_interval: got %0d want 256", i - last_tx); end
            end
            last_tx = i;
         end
      end
      checks++;
      if (n_iv < 30) begin errors++; $display("FAIL rx_interval_count: got %0d want >=30", n_iv); end
      step(1'b1, 1'b1, 16'd0, 1'b0);
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         if ((rxclk_en | txclk_en | rx_sample) !== 1'b0) n_after_zero++;
      end
      checks++;
      if (n_after_zero != 0) begin errors++; $display("FAIL zero_inc pulses: got %0d want 0", n_after_zero); end
   endtask

   task automatic test_enable_gating();
      int found = -1, next_rx = -1, cyc = 0;
      step(1'b1, 1'b1, 16'd4096, 1'b0);
      for (int i = 0; i < 40 && found < 0; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         if (rxclk_en === 1'b1) found = i;
      end
      checks++;
      if (found < 0) begin errors++; $display("FAIL gating_start: no rxclk_en within 40 cycles"); end
      for (int i = 0; i < 5; i++) begin step(1'b1, 1'b0, '0, 1'b0); cyc++; end
      for (int i = 0; i < 37; i++) begin
         step(1'b0, 1'b0, '0, 1'b0); cyc++;
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== 3'b000) begin
            errors++;
            $display("FAIL gated_outputs cycle %0d: got %b%b%b want 000", i, rxclk_en, txclk_en, rx_sample);
         end
      end
      for (int i = 0; i < 60 && next_rx < 0; i++) begin
         step(1'b1, 1'b0, '0, 1'b0); cyc++;
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== {exp_rx, exp_tx, exp_smp}) begin
            errors++;
            $display("FAIL gating_resume cycle %0d: got %b%b%b want %b%b%b",
                     i, rxclk_en, txclk_en, rx_sample, exp_rx, exp_tx, exp_smp);
         end
         if (rxclk_en === 1'b1) next_rx = cyc;
      end
      checks++;
      if (next_rx != 53) begin errors++; $display("FAIL gating_shift: got interval %0d want 53", next_rx); end
   endtask

   task automatic test_resync();
      step(1'b1, 1'b1, 16'd4096, 1'b0);
      for (int pass = 0; pass < 2; pass++) begin
         int k = 0;
         bit ok = 0;
         for (int i = 0; i < 40 && !ok; i++) begin
            if (((m_phase + m_inc) >= MOD) == (pass == 1)) ok = 1;
            else step(1'b1, 1'b0, '0, 1'b0);
         end
         checks++;
         if (!ok) begin errors++; $display("FAIL resync_setup pass %0d: sync slot not reached", pass); end
         step(1'b1, 1'b0, '0, 1'b1);
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== {exp_rx, exp_tx, exp_smp}) begin
            errors++;
            $display("FAIL resync_edge pass %0d: got %b%b%b want %b%b%b",
                     pass, rxclk_en, txclk_en, rx_sample, exp_rx, exp_tx, exp_smp);
         end
         if (pass == 1) begin
            checks++;
            if (rxclk_en !== 1'b1 || rx_sample !== 1'b0) begin
               errors++;
               $display("FAIL sync_on_tick: got rx=%b smp=%b want rx=1 smp=0", rxclk_en, rx_sample);
            end
         end
         for (int i = 0; i < 16 * 42; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (rxclk_en === 1'b1) begin
               k++;
               checks++;
               if (rx_sample !== 1'(k % OS == OS / 2)) begin
                  errors++;
                  $display("FAIL resync_sample pass %0d rx #%0d: got %b want %b", pass, k, rx_sample, (k % OS == OS / 2));
               end
            end else if (rx_sample !== 1'b0) begin
               checks++; errors++;
               $display("FAIL resync_sample pass %0d: rx_sample without rxclk_en", pass);
            end
         end
         checks++;
         if (k != 42) begin errors++; $display("FAIL resync_tick_count pass %0d: got %0d want 42", pass, k); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         logic e, ld, sy;
         logic [W-1:0] v;
         int r;
         e  = ($urandom_range(0, 9) != 0);
         ld = ($urandom_range(0, 49) == 0);
         sy = ($urandom_range(0, 63) == 0);
         r  = $urandom_range(0, 9);
         v  = (r == 0) ? '0 : (r == 1) ? W'($urandom_range(32768, 65535)) : W'($urandom_range(1, 9000));
         step(e, ld, v, sy);
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== {exp_rx, exp_tx, exp_smp}) begin
            errors++;
            $display("FAIL random cycle %0d: got %b%b%b want %b%b%b",
                     i, rxclk_en, txclk_en, rx_sample, exp_rx, exp_tx, exp_smp);
         end
      end
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      int first_rx = 0, n_rx = 0, n_tx = 0;
      step(1'b1, 1'b1, 16'd4096, 1'b0);
      for (int i = 0; i < 600 && !found; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         if (exp_tx) found = 1;
      end
      checks++;
      if (!found || txclk_en !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_setup: tx pulse got %b want 1", txclk_en);
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({rxclk_en, txclk_en, rx_sample} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset outputs: got %b%b%b want 000", rxclk_en, txclk_en, rx_sample);
      end
      model_reset();
      @(negedge clk_50m);
      rst_n = 1'b1;
      for (int i = 1; i <= 4096; i++) begin
         step(1'b1, 1'b0, '0, 1'b0);
         checks++;
         if ({rxclk_en, txclk_en, rx_sample} !== {exp_rx, exp_tx, exp_smp}) begin
            errors++;
            $display("FAIL post_reset edge %0d: got %b%b%b want %b%b%b",
                     i, rxclk_en, txclk_en, rx_sample, exp_rx, exp_tx, exp_smp);
         end
         if (rxclk_en === 1'b1) begin n_rx++; if (first_rx == 0) first_rx = i; end
         if (txclk_en === 1'b1) n_tx++;
      end
      checks++; if (first_rx != 35) begin errors++; $display("FAIL post_reset first_rx: got %0d want 35", first_rx); end
      checks++; if (n_rx != 117)    begin errors++; $display("FAIL post_reset rx_count: got %0d want 117", n_rx); end
      checks++; if (n_tx != 7)      begin errors++; $display("FAIL post_reset tx_count: got %0d want 7", n_tx); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_default_rate();
      test_reprogram();
      test_enable_gating();
      test_resync();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
